// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall controller for a five-stage pipeline: load-use bubbles, branch
// flushes, memory wait with timeout, and saturating stall/flush statistics.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; hazards resolved combinationally this cycle
// MEM_WAIT | data memory access outstanding, IF/ID/EX frozen, timeout armed
// ERROR    | memory timeout; pipeline held and bubbled until reset
module pipeline_hazard_controller (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  ID_Rn,
  input  logic [3:0]  ID_Rm,
  input  logic        ID_Rn_Used,
  input  logic        ID_Rm_Used,
  input  logic        EX_Load,
  input  logic        EX_rf,
  input  logic [3:0]  EX_Rd,
  input  logic        Branch_Taken,
  input  logic        Mem_Access,
  input  logic        Mem_Ready,
  output logic        PC_LE,
  output logic        IFID_LE,
  output logic        EXMEM_LE,
  output logic        IFID_CLR,
  output logic        IDEX_CLR,
  output logic        MEMWB_CLR,
  output logic        Error,
  output logic [1:0]  State,
  output logic [15:0] Stall_Count,
  output logic [7:0]  Flush_Count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       mem_stall;
  logic       load_use;
  logic       flush_evt;

  assign mem_stall = Mem_Access & ~Mem_Ready;
  assign load_use  = EX_Load & EX_rf &
                     ((ID_Rn_Used & (ID_Rn == EX_Rd)) |
                      (ID_Rm_Used & (ID_Rm == EX_Rd)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= RUN;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    flush_evt    = 1'b0;
    PC_LE        = 1'b1;
    IFID_LE      = 1'b1;
    EXMEM_LE     = 1'b1;
    IFID_CLR     = 1'b0;
    IDEX_CLR     = 1'b0;
    MEMWB_CLR    = 1'b0;

    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          PC_LE     = 1'b0;
          IFID_LE   = 1'b0;
          EXMEM_LE  = 1'b0;
          MEMWB_CLR = 1'b1;
          if (state == RUN) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 4'd0;
          end else if (wait_cnt == 4'hF) begin
            state_nxt = ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end else begin
          // Releasing from MEM_WAIT resolves the other hazards in the same cycle.
          state_nxt = RUN;
          if (Branch_Taken) begin
            IFID_CLR  = 1'b1;
            IDEX_CLR  = 1'b1;
            flush_evt = 1'b1;
          end else if (load_use) begin
            PC_LE    = 1'b0;
            IFID_LE  = 1'b0;
            IDEX_CLR = 1'b1;
          end
        end
      end
      default: begin
        PC_LE     = 1'b0;
        IFID_LE   = 1'b0;
        EXMEM_LE  = 1'b0;
        IFID_CLR  = 1'b1;
        IDEX_CLR  = 1'b1;
        MEMWB_CLR = 1'b1;
      end
    endcase

    // Hold the pipeline and bubble every stage for as long as reset is low.
    if (!RST_N) begin
      flush_evt = 1'b0;
      PC_LE     = 1'b0;
      IFID_LE   = 1'b0;
      EXMEM_LE  = 1'b0;
      IFID_CLR  = 1'b1;
      IDEX_CLR  = 1'b1;
      MEMWB_CLR = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Stall_Count <= 16'd0;
      Flush_Count <= 8'd0;
    end else begin
      if (!PC_LE && (Stall_Count != 16'hFFFF))
        Stall_Count <= Stall_Count + 16'd1;
      if (flush_evt && (Flush_Count != 8'hFF))
        Flush_Count <= Flush_Count + 8'd1;
    end
  end

  assign Error = (state != RUN) && (state != MEM_WAIT);
  assign State = state;

endmodule
